// File: rtl/wb_ram_slave.sv
// wb_ram_slave
//   Wishbone classic-cycle RAM responder. Word-organised storage; writes honour
//   the sel_i byte enables, reads return the full word. A programmable number
//   of wait states sits between request capture and termination. Illegal lane
//   masks and out-of-range addresses terminate with err_o instead of ack_o.
//
// Ports
//   clk_i     system clock, rising edge
//   rst_n_i   asynchronous active-low reset
//   cyc_i     bus cycle in progress (checked during wait states for abort)
//   stb_i     transfer strobe
//   we_i      1 = write, 0 = read
//   adr_i     word address
//   sel_i     byte-lane enables, lane n = bits 8n+7:8n
//   dat_i     lane-positioned write data
//   dat_o     read data, full word, held until the next successful read
//   ack_o     normal termination, one-cycle pulse
//   err_o     error termination, one-cycle pulse
//
// state | meaning
// IDLE  | waiting for cyc_i & stb_i, request captured on acceptance
// WAIT  | counting down wait states, cyc_i low aborts the transfer
// RESP  | ack_o or err_o high for this single cycle
module wb_ram_slave #(
  parameter int XLEN        = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] adr_i,
  input  logic [XLEN/8-1:0]     sel_i,
  input  logic [XLEN-1:0]       dat_i,
  output logic [XLEN-1:0]       dat_o,
  output logic                  ack_o,
  output logic                  err_o
);

  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [XLEN/8-1:0]     sel_q;
  logic [XLEN-1:0]       wdat_q;
  logic [XLEN-1:0]       rdat_q;
  logic                  ack_q, err_q;

  logic [XLEN-1:0]       mem_q [DEPTH];

  logic                  in_idle, accept, enter_resp;
  logic                  cur_we;
  logic [ADDR_WIDTH-1:0] cur_adr;
  logic [XLEN/8-1:0]     cur_sel;
  logic [XLEN-1:0]       cur_dat;
  logic                  lanes_ok, adr_ok, req_ok;
  logic [MEM_AW-1:0]     mem_idx;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (cyc_i && stb_i) begin
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (!cyc_i) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the request goes straight from IDLE to RESP, so the
  // live bus inputs must be used on that edge; otherwise the captured copy.
  assign in_idle    = (state_q == IDLE);
  assign accept     = in_idle && cyc_i && stb_i;
  assign enter_resp = (state_d == RESP) && (state_q != RESP);
  assign cur_we     = in_idle ? we_i  : we_q;
  assign cur_adr    = in_idle ? adr_i : adr_q;
  assign cur_sel    = in_idle ? sel_i : sel_q;
  assign cur_dat    = in_idle ? dat_i : wdat_q;
  assign mem_idx    = MEM_AW'(cur_adr);

  always_comb begin
    lanes_ok = 1'b0;
    case (cur_sel)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: lanes_ok = 1'b1;
      default:                   lanes_ok = 1'b0;
    endcase
  end

  assign adr_ok = int'(cur_adr) < DEPTH;
  assign req_ok = lanes_ok && adr_ok;

  always_ff @(posedge clk_i) begin
    if (enter_resp && req_ok && cur_we) begin
      for (int b = 0; b < XLEN/8; b++) begin
        if (cur_sel[b]) mem_q[mem_idx][8*b +: 8] <= cur_dat[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= enter_resp && req_ok;
      err_q   <= enter_resp && !req_ok;
      if (accept) begin
        we_q   <= we_i;
        adr_q  <= adr_i;
        sel_q  <= sel_i;
        wdat_q <= dat_i;
      end
      if (enter_resp && req_ok && !cur_we) rdat_q <= mem_q[mem_idx];
    end
  end

  assign dat_o = rdat_q;
  assign ack_o = ack_q;
  assign err_o = err_q;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Bench for wb_ram_slave: three instances (1, 3 and 0 wait states, DEPTH=1000
// so that adr=DEPTH is representable) share the bus signals except cyc.
// A transaction-timeline model predicts ack/err/dat for every cycle.
module tb_wb_ram_slave;

  localparam int DEPTH = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  cyc;
  logic        stb, we;
  logic [9:0]  adr;
  logic [3:0]  sel;
  logic [31:0] wdat;
  logic [2:0]  ack_w, err_w;
  logic [31:0] dat_w [3];

  always #5 clk = ~clk;

  wb_ram_slave #(.XLEN(32), .ADDR_WIDTH(10), .DEPTH(DEPTH), .WAIT_STATES(1)) u_ws1 (
    .clk_i(clk), .rst_n_i(rst_n), .cyc_i(cyc[0]), .stb_i(stb), .we_i(we), .adr_i(adr),
    .sel_i(sel), .dat_i(wdat), .dat_o(dat_w[0]), .ack_o(ack_w[0]), .err_o(err_w[0]));
  wb_ram_slave #(.XLEN(32), .ADDR_WIDTH(10), .DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
    .clk_i(clk), .rst_n_i(rst_n), .cyc_i(cyc[1]), .stb_i(stb), .we_i(we), .adr_i(adr),
    .sel_i(sel), .dat_i(wdat), .dat_o(dat_w[1]), .ack_o(ack_w[1]), .err_o(err_w[1]));
  wb_ram_slave #(.XLEN(32), .ADDR_WIDTH(10), .DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .clk_i(clk), .rst_n_i(rst_n), .cyc_i(cyc[2]), .stb_i(stb), .we_i(we), .adr_i(adr),
    .sel_i(sel), .dat_i(wdat), .dat_o(dat_w[2]), .ack_o(ack_w[2]), .err_o(err_w[2]));

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: edge-numbered transaction timeline ----------------
  int          ws_of [3] = '{1, 3, 0};
  bit [31:0]   mmem [3][1024];
  bit          exp_ack [3];
  bit          exp_err [3];
  bit [31:0]   exp_dat [3];
  bit          busy [3];
  int          term_e [3];
  int          free_e [3];
  bit          c_we [3];
  bit [9:0]    c_adr [3];
  bit [3:0]    c_sel [3];
  bit [31:0]   c_dat [3];
  int          ecount = 0;

  function automatic void terminate(input int k);
    bit ok;
    ok = (c_sel[k] inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111})
         && (int'(c_adr[k]) < DEPTH);
    exp_ack[k] = ok;
    exp_err[k] = !ok;
    if (ok) begin
      if (c_we[k]) begin
        for (int b = 0; b < 4; b++)
          if (c_sel[k][b]) mmem[k][c_adr[k]][8*b +: 8] = c_dat[k][8*b +: 8];
      end else begin
        exp_dat[k] = mmem[k][c_adr[k]];
      end
    end
    busy[k]   = 1'b0;
    free_e[k] = ecount + 2;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < 3; k++) begin
          busy[k] = 0; exp_ack[k] = 0; exp_err[k] = 0; exp_dat[k] = 0; free_e[k] = 0;
        end
      end else begin
        ecount++;
        for (int k = 0; k < 3; k++) begin
          exp_ack[k] = 0;
          exp_err[k] = 0;
          if (busy[k]) begin
            if (!cyc[k]) begin
              busy[k]   = 0;
              free_e[k] = ecount + 1;
            end else if (ecount == term_e[k]) begin
              terminate(k);
            end
          end else if (ecount >= free_e[k] && cyc[k] && stb) begin
            c_we[k]   = we;
            c_adr[k]  = adr;
            c_sel[k]  = sel;
            c_dat[k]  = wdat;
            term_e[k] = ecount + ws_of[k];
            busy[k]   = 1;
            if (ws_of[k] == 0) terminate(k);
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("cyc_ack%0d", k), 32'(ack_w[k]), 32'(exp_ack[k]));
        chk($sformatf("cyc_err%0d", k), 32'(err_w[k]), 32'(exp_err[k]));
        chk($sformatf("cyc_dat%0d", k), dat_w[k], exp_dat[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic xfer(input int k, input bit w, input bit [9:0] a, input bit [3:0] s,
                      input bit [31:0] d, output bit got_ack, output bit got_err,
                      output int lat);
    @(negedge clk);
    cyc[k] = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
    got_ack = 0; got_err = 0; lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (ack_w[k] || err_w[k]) begin
        got_ack = ack_w[k];
        got_err = err_w[k];
        break;
      end
    end
    if (!got_ack && !got_err) begin
      n_assert++; n_fail++;
      $display("FAIL timeout: instance %0d got no termination within 20 cycles", k);
    end
    @(negedge clk);
    cyc[k] = 1'b0; stb = 1'b0;
  endtask

  bit a, e;
  int lat;
  int hits;
  logic [3:0] pat;

  initial begin
    cyc = 0; stb = 0; we = 0; adr = 0; sel = 0; wdat = 0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_ack", 32'(ack_w), 32'd0);
    chk("reset_err", 32'(err_w), 32'd0);
    chk("reset_dat", dat_w[0] | dat_w[1] | dat_w[2], 32'd0);

    // 1: full-word write then read, WS=1
    xfer(0, 1, 10'd5, 4'b1111, 32'hDEADBEEF, a, e, lat);
    chk("t1_wr_ack", 32'(a), 32'd1);
    chk("t1_wr_lat", 32'(lat), 32'd2);
    xfer(0, 0, 10'd5, 4'b1111, 32'h0, a, e, lat);
    chk("t1_rd_ack", 32'(a), 32'd1);
    chk("t1_rd_lat", 32'(lat), 32'd2);
    chk("t1_rd_dat", dat_w[0], 32'hDEADBEEF);

    // 2: byte then upper-half writes
    xfer(0, 1, 10'd5, 4'b0010, 32'h0000AA00, a, e, lat);
    xfer(0, 1, 10'd5, 4'b1100, 32'h12340000, a, e, lat);
    xfer(0, 0, 10'd5, 4'b0001, 32'h0, a, e, lat);
    chk("t2_rd_dat", dat_w[0], 32'h1234AAEF);

    // 3: illegal masks and out-of-range address
    xfer(0, 1, 10'd5, 4'b0101, 32'hFFFFFFFF, a, e, lat);
    chk("t3_mask_err", 32'(e), 32'd1);
    chk("t3_mask_ack", 32'(a), 32'd0);
    chk("t3_mask_lat", 32'(lat), 32'd2);
    xfer(0, 0, 10'(DEPTH), 4'b1111, 32'h0, a, e, lat);
    chk("t3_oor_err", 32'(e), 32'd1);
    chk("t3_oor_dat", dat_w[0], 32'h1234AAEF);
    xfer(0, 1, 10'd5, 4'b0000, 32'hFFFFFFFF, a, e, lat);
    chk("t3_zero_err", 32'(e), 32'd1);
    xfer(0, 1, 10'd5, 4'b0011, 32'h00005678, a, e, lat);
    xfer(0, 0, 10'd5, 4'b1111, 32'h0, a, e, lat);
    chk("t3_half_dat", dat_w[0], 32'h12345678);

    // 4: abort during the second wait cycle, WS=3
    xfer(1, 1, 10'd7, 4'b1111, 32'hCAFE0007, a, e, lat);
    chk("t4_wr_lat", 32'(lat), 32'd4);
    @(negedge clk);
    cyc[1] = 1; stb = 1; we = 1; adr = 10'd7; sel = 4'b1111; wdat = 32'h11111111;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    cyc[1] = 0; stb = 0;
    hits = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack_w[1] || err_w[1]) hits++;
    end
    chk("t4_abort_term", 32'(hits), 32'd0);
    xfer(1, 0, 10'd7, 4'b1111, 32'h0, a, e, lat);
    chk("t4_rd_dat", dat_w[1], 32'hCAFE0007);

    // 5: asynchronous reset in the middle of a write's wait states
    xfer(1, 1, 10'd9, 4'b1111, 32'hA5A5A5A5, a, e, lat);
    @(negedge clk);
    cyc[1] = 1; stb = 1; we = 1; adr = 10'd9; sel = 4'b1111; wdat = 32'h5A5A5A5A;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_rst_ack", 32'(ack_w), 32'd0);
    chk("t5_rst_err", 32'(err_w), 32'd0);
    chk("t5_rst_dat1", dat_w[1], 32'd0);
    chk("t5_rst_dat0", dat_w[0], 32'd0);
    cyc[1] = 0; stb = 0;
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack_w[1] || err_w[1]) hits++;
    end
    chk("t5_no_term", 32'(hits), 32'd0);
    xfer(1, 0, 10'd9, 4'b1111, 32'h0, a, e, lat);
    chk("t5_rd_dat", dat_w[1], 32'hA5A5A5A5);

    // 6: WS=0 with stb held across the first ack
    @(negedge clk);
    cyc[2] = 1; stb = 1; we = 1; adr = 10'd3; sel = 4'b1111; wdat = 32'h0BADF00D;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      pat[i] = ack_w[2];
      if (i == 2) begin
        cyc[2] = 0; stb = 0;
      end
    end
    chk("t6_ack_pattern", 32'(pat), 32'b0101);
    xfer(2, 0, 10'd3, 4'b1111, 32'h0, a, e, lat);
    chk("t6_rd_lat", 32'(lat), 32'd1);
    chk("t6_rd_dat", dat_w[2], 32'h0BADF00D);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
